// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: multi-cycle unsigned N x N -> 2N shift-add multiplier.
// One N-bit ripple-carry adder is reused for N iterations. The product sits
// in hi/lo and is valid from the done pulse until the next accepted start
// or rst.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - multiply request, sampled only in IDLE
//   a, b  - multiplicand / multiplier, captured when start is accepted
//   busy  - high while iterating (RUN)
//   done  - one-cycle pulse, hi/lo hold the final product
//   hi/lo - upper/lower half of the product register

module rc_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         c
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c = carry[W];
endmodule

module mult_seq_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  m_reg;
  logic [N-1:0]  hi_reg;
  logic [N-1:0]  lo_reg;

  logic [N-1:0] sum;
  logic         carry;

  // The shared adder always sees hi + m; its result is only used when the
  // current multiplier bit (lo[0]) is set.
  rc_adder #(.W(N)) u_adder (
    .a (hi_reg),
    .b (m_reg),
    .s (sum),
    .c (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      m_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            m_reg     <= a;
            hi_reg    <= '0;
            lo_reg    <= b;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // The {hi,lo} pair shifts right one bit per iteration. The bit
          // shifted out of hi (or the sum) fills the top of lo, while the
          // multiplier bits already consumed leave through the bottom of lo.
          if (lo_reg[0]) begin
            hi_reg <= {carry, sum[N-1:1]};
            lo_reg <= {sum[0], lo_reg[N-1:1]};
          end else begin
            hi_reg <= {1'b0, hi_reg[N-1:1]};
            lo_reg <= {hi_reg[0], lo_reg[N-1:1]};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl. The expected product is computed
// with plain 64-bit multiplication. The expected handshake timing comes
// from the cycle position relative to the accept edge.
module tb_mult_seq_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int vectors = 0;
  int miscompares = 0;

  mult_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Runs one multiply from IDLE. If poke is in the range 1..N+1, start is
  // raised again with other operands in that cycle; it must be ignored.
  task automatic mul(input logic [N-1:0] x, input logic [N-1:0] y, input int poke);
    logic [63:0] prod;
    prod = {32'd0, x} * {32'd0, y};
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    for (int k = 0; k <= N + 1; k++) begin
      @(posedge clk);
      #1;
      if (k < N) begin
        check("busy_run", {63'd0, busy}, 64'd1);
        check("done_run", {63'd0, done}, 64'd0);
      end else if (k == N) begin
        check("busy_done", {63'd0, busy}, 64'd0);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("product", {hi, lo}, prod);
      end else begin
        check("idle_flags", {62'd0, busy, done}, 64'd0);
        check("product_held", {hi, lo}, prod);
      end
      @(negedge clk);
      start = (k + 1 == poke);
      a = (k + 1 == poke) ? 32'd1 : $urandom;
      b = (k + 1 == poke) ? 32'd1 : $urandom;
    end
    $display("mul a=%h b=%h -> hi=%h lo=%h (exp %h)", x, y, hi, lo, prod);
    start = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ca, cb;
    logic [63:0]  prod;
    int ph;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    rst = 1'b0;

    mul(32'd3, 32'd5, -1);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    mul(32'h8000_0000, 32'd2, -1);
    mul(32'h0000_1234, 32'd0, -1);
    mul(32'd7, 32'd6, 10);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    a = 32'hFFFF;
    b = 32'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_run", {busy, done, hi, lo}, 66'd0);
    $display("reset mid-run -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    rst = 1'b0;
    mul(32'd2, 32'd9, -1);

    // Random operands, some with a stray start while busy or done.
    for (int i = 0; i < 8; i++) begin
      mul($urandom, $urandom, (i % 2 == 1) ? int'($urandom_range(1, N + 1)) : -1);
    end

    // start held high: accepts only from IDLE, every N+2 cycles, and each
    // result belongs to the operands present at its accept edge.
    ca = '0;
    cb = '0;
    for (int c = 0; c < 3 * (N + 2); c++) begin
      @(negedge clk);
      start = 1'b1;
      a = $urandom;
      b = $urandom;
      ph = c % (N + 2);
      if (ph == 0) begin
        ca = a;
        cb = b;
      end
      @(posedge clk);
      #1;
      if (ph < N) begin
        check("b2b_busy", {62'd0, busy, done}, 64'd2);
      end else if (ph == N) begin
        prod = {32'd0, ca} * {32'd0, cb};
        check("b2b_done", {62'd0, busy, done}, 64'd1);
        check("b2b_product", {hi, lo}, prod);
        $display("b2b a=%h b=%h -> hi=%h lo=%h (exp %h)", ca, cb, hi, lo, prod);
      end else begin
        check("b2b_idle", {62'd0, busy, done}, 64'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
